// File: rtl/button_conditioner.sv
// Synchronizes and debounces four active-low buttons, emitting one active-low
// single-cycle pulse per press on switch, with optional auto-repeat while held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] switch,
  output logic [3:0] pressed
);

  localparam int unsigned MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int          CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    HELD    = 3'd2,
    REPEAT  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sw_q;
    logic          prs_q;
    logic          s;

    assign s = sync2_q[i];

    // A pulse is only issued when the previous cycle was high, so back-to-back
    // terminal counts (period 1) still leave a gap between pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sw_q    <= 1'b1;
        prs_q   <= 1'b0;
      end else begin
        sw_q  <= 1'b1;
        cnt_q <= cnt_q + CW'(1);
        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (!s) state_q <= ARM;
          end
          ARM: begin
            if (s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
              prs_q   <= 1'b1;
              if (sw_q) sw_q <= 1'b0;
            end
          end
          HELD: begin
            if (s) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
            end else if (cnt_q == HOLD_LAST) begin
              if (REPEAT_EN) begin
                state_q <= REPEAT;
                cnt_q   <= '0;
                if (sw_q) sw_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q;
              end
            end
          end
          REPEAT: begin
            if (s) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
            end else if (cnt_q == REP_LAST) begin
              cnt_q <= '0;
              if (sw_q) sw_q <= 1'b0;
            end
          end
          RELEASE: begin
            if (!s) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              prs_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign switch[i]  = sw_q;
    assign pressed[i] = prs_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, HOLD=8, REPEAT=3; one
// instance with auto-repeat and one without, driven by the same buttons.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] switch_rep, pressed_rep;
  logic [3:0] switch_nr, pressed_nr;

  int n_checks;
  int n_err;
  int k;

  logic [3:0] sw_r  [0:63];
  logic [3:0] pr_r  [0:63];
  logic [3:0] swn_r [0:63];
  logic [3:0] prn_r [0:63];

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .switch(switch_rep), .pressed(pressed_rep)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_n(btn_n), .switch(switch_nr), .pressed(pressed_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge that samples b; outputs after that edge land in entry k.
  task automatic step(input logic [3:0] b);
    btn_n = b;
    @(posedge clk);
    #1;
    if (k < 64) begin
      sw_r[k]  = switch_rep;
      pr_r[k]  = pressed_rep;
      swn_r[k] = switch_nr;
      prn_r[k] = pressed_nr;
    end
    k++;
  endtask

  task automatic steps(input logic [3:0] b, input int n);
    for (int j = 0; j < n; j++) step(b);
  endtask

  // which: 0 switch low (rep), 1 pressed (rep), 2 switch low (no-rep), 3 pressed (no-rep)
  function automatic logic [63:0] col(input int which, input int b, input int n);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < n && j < 64; j++) begin
      case (which)
        0:       m[j] = ~sw_r[j][b];
        1:       m[j] = pr_r[j][b];
        2:       m[j] = ~swn_r[j][b];
        default: m[j] = prn_r[j][b];
      endcase
    end
    return m;
  endfunction

  logic [63:0] exp_v;

  initial begin
    n_checks = 0;
    n_err    = 0;
    k        = 0;
    rst      = 1'b1;
    btn_n    = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_switch", {switch_rep, switch_nr}, 8'hFF);
    check("reset_pressed", {pressed_rep, pressed_nr}, 8'h00);
    rst = 1'b0;
    steps(4'hF, 5);

    // Reset in the middle of a held press, then re-debounce from IDLE
    k = 0;
    steps(4'b1110, 7);
    check("pre_rst_pulse", sw_r[6], 4'b1110);
    check("pre_rst_pressed", pr_r[6], 4'b0001);
    rst = 1'b1;
    #2;
    check("midpress_rst_switch", {switch_rep, switch_nr}, 8'hFF);
    check("midpress_rst_pressed", {pressed_rep, pressed_nr}, 8'h00);
    #2;
    rst = 1'b0;
    k = 0;
    steps(4'b1110, 7);
    check("redeb_not_yet", {pr_r[5], sw_r[5]}, 8'h0F);
    check("redeb_pulse", {pr_r[6], sw_r[6]}, {4'b0001, 4'b1110});
    steps(4'hF, 20);

    // Clean press, no auto-repeat: one pulse at 6, pressed 6..45
    k = 0;
    steps(4'b1110, 40);
    steps(4'hF, 10);
    exp_v = '0;
    exp_v[6] = 1'b1;
    check("clean_pulse_vec", col(2, 0, 50), exp_v);
    exp_v = '0;
    for (int j = 6; j <= 45; j++) exp_v[j] = 1'b1;
    check("clean_pressed_vec", col(3, 0, 50), exp_v);
    check("clean_other_bits", {swn_r[6][3:1], prn_r[6][3:1]}, 6'b111_000);
    steps(4'hF, 20);

    // Bounce: 3 low / 1 high x5 never reaches the debounce count
    k = 0;
    for (int r = 0; r < 5; r++) begin
      steps(4'b1101, 3);
      step(4'hF);
    end
    steps(4'hF, 10);
    check("bounce_no_pulse_rep", col(0, 1, 30), 64'h0);
    check("bounce_no_pulse_nr", col(2, 1, 30), 64'h0);
    check("bounce_no_pressed", col(1, 1, 30) | col(3, 1, 30), 64'h0);
    steps(4'hF, 20);

    // Auto-repeat: pulses at 6, 14, then every 3 while held
    k = 0;
    steps(4'b1011, 30);
    steps(4'hF, 10);
    exp_v = '0;
    exp_v[6] = 1'b1;
    for (int p = 14; p < 30; p += 3) exp_v[p] = 1'b1;
    check("repeat_pulse_vec", col(0, 2, 40), exp_v);
    exp_v = '0;
    exp_v[6] = 1'b1;
    check("norepeat_pulse_vec", col(2, 2, 40), exp_v);
    check("repeat_release", {pr_r[35][2], pr_r[36][2]}, 2'b10);
    steps(4'hF, 20);

    // Release glitch: 2-cycle high blip must not add a press
    k = 0;
    steps(4'b0111, 8);
    steps(4'hF, 2);
    steps(4'b0111, 4);
    steps(4'hF, 12);
    exp_v = '0;
    exp_v[6] = 1'b1;
    check("glitch_pulse_vec", col(0, 3, 26), exp_v);
    exp_v = '0;
    for (int j = 6; j <= 19; j++) exp_v[j] = 1'b1;
    check("glitch_pressed_vec", col(1, 3, 26), exp_v);
    steps(4'hF, 20);

    // Simultaneous press on two channels
    k = 0;
    steps(4'b1100, 8);
    steps(4'hF, 10);
    check("simul_before", swn_r[5], 4'b1111);
    check("simul_pulse", {swn_r[6], sw_r[6]}, {4'b1100, 4'b1100});
    check("simul_after", swn_r[7], 4'b1111);
    check("simul_pressed", prn_r[6], 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
